// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the MEM stage and a word-wide data memory.
// Ports: req_* (valid/ready request in), resp_* (one-cycle response), mem_* (word memory side).
module dmem_lsu #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_DEPTH      = 1024,
  parameter int REG_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]       req_wdata,
  output logic                       resp_valid,
  output logic [REG_WIDTH-1:0]       resp_rdata,
  output logic                       resp_err,
  output logic                       mem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]       mem_wr_data,
  input  logic [REG_WIDTH-1:0]       mem_rd_data
);

  localparam int AW = DMEM_ADDR_WIDTH;
  localparam logic [31:0] LAST_WORD = 32'(DMEM_DEPTH - 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_RMW_WR,
    S_WR,
    S_ERR,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]  word_q, word_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [AW-1:0]         req_word;
  logic [31:0]           req_word_ext;
  logic                  f3_ok;
  logic                  misal;
  logic                  req_err;

  logic [AW-1:0]         word_addr;
  logic [4:0]            shamt;
  logic [31:0]           lane_data;
  logic [31:0]           lane_mask;
  logic [31:0]           merged;
  logic [31:0]           shifted;
  logic [31:0]           load_val;

  assign req_ready    = (state_q == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign req_word     = {req_addr[AW-1:2], 2'b00};
  assign req_word_ext = 32'(req_word);

  // Stores only have B/H/W; loads add BU/HU.
  always_comb begin
    f3_ok = 1'b0;
    misal = 1'b0;
    case (req_funct3)
      3'b000: f3_ok = 1'b1;
      3'b001: begin
        f3_ok = 1'b1;
        misal = req_addr[0];
      end
      3'b010: begin
        f3_ok = 1'b1;
        misal = |req_addr[1:0];
      end
      3'b100: f3_ok = !req_we;
      3'b101: begin
        f3_ok = !req_we;
        misal = req_addr[0];
      end
      default: f3_ok = 1'b0;
    endcase
  end

  assign req_err = !f3_ok || misal
                || (req_word_ext > LAST_WORD);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          word_d  = '0;
          if (req_err)
            state_d = S_ERR;
          else if (!req_we)
            state_d = S_RD;
          else if (req_funct3 == 3'b010)
            state_d = S_WR;
          else
            state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        word_d  = mem_rd_data;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        word_d  = mem_rd_data;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_WR:     state_d = S_RESP;
      S_ERR:    state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign word_addr = {addr_q[AW-1:2], 2'b00};
  assign shamt     = {addr_q[1:0], 3'b000};

  // f3_q[0] separates SH from SB; the lane mask keeps the rest of the old word.
  always_comb begin
    if (f3_q[0]) begin
      lane_data = {16'h0000, wdata_q[15:0]} << shamt;
      lane_mask = 32'h0000_ffff << shamt;
    end else begin
      lane_data = {24'h00_0000, wdata_q[7:0]} << shamt;
      lane_mask = 32'h0000_00ff << shamt;
    end
    merged = (word_q & ~lane_mask) | lane_data;
  end

  assign shifted = word_q >> shamt;

  always_comb begin
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h00_0000, shifted[7:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = word_q;
    endcase
  end

  // Memory and response outputs depend on registered state only.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    unique case (state_q)
      S_RD, S_RMW_RD: mem_addr = word_addr;
      S_RMW_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = word_addr;
        mem_wr_data = merged;
      end
      S_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = word_addr;
        mem_wr_data = wdata_q;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : load_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed + random bench for dmem_lsu with a word memory
// and an arithmetic reference model of memory contents and responses.
module tb_dmem_lsu;

  localparam int AW    = 10;
  localparam int DEPTH = 256;
  localparam int NW    = DEPTH / 4;
  localparam int IW    = $clog2(NW);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  always #5 clk = ~clk;

  dmem_lsu #(
    .DMEM_ADDR_WIDTH(AW),
    .DMEM_DEPTH(DEPTH),
    .REG_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Environment memory: asynchronous read, write at posedge.
  logic [31:0]   mem [NW];
  logic [AW-3:0] mem_idx;
  logic          tb_clear;

  assign mem_idx = mem_addr[AW-1:2];
  assign mem_rd_data = (int'(mem_idx) < NW) ? mem[mem_idx[IW-1:0]] : 32'h0;

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'h0;
    end else if (mem_wr_en && int'(mem_idx) < NW) begin
      mem[mem_idx[IW-1:0]] <= mem_wr_data;
    end
  end

  // Reference model: expected memory image.
  logic [31:0] model [NW];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic we, input logic [2:0] f3,
                                   input logic [AW-1:0] a);
    int unsigned ad = a;
    int unsigned wa = (ad / 4) * 4;
    int unsigned off = ad % 4;
    bit legal;
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                     f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    if (wa > DEPTH - 4) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                             input logic [AW-1:0] a);
    int unsigned ad = a;
    logic [31:0] v = model[ad / 4] >> (8 * (ad % 4));
    logic [31:0] b = v & 32'hff;
    logic [31:0] h = v & 32'hffff;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return model[ad / 4];
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3,
                                              input logic [AW-1:0] a,
                                              input logic [31:0] wd);
    int unsigned ad = a;
    int unsigned sh = 8 * (ad % 4);
    logic [31:0] old = model[ad / 4];
    logic [31:0] m;
    case (f3)
      3'd0: begin
        m = 32'hff << sh;
        return (old & ~m) | ((wd & 32'hff) << sh);
      end
      3'd1: begin
        m = 32'hffff << sh;
        return (old & ~m) | ((wd & 32'hffff) << sh);
      end
      default: return wd;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input string tag);
    bit e_err;
    logic [31:0] e_rd;
    int e_lat, e_nwr;
    logic [31:0] e_wdata;
    logic [AW-1:0] e_waddr;
    int lat = 0;
    int nwr = 0;
    logic [31:0] wa_seen = 32'h0;
    logic [31:0] wd_seen = 32'h0;
    logic [31:0] rd_seen = 32'h0;
    logic er_seen = 1'b0;
    bit bad = 1'b0;
    int unsigned ad = a;

    e_err   = model_err(we, f3, a);
    e_rd    = (e_err || we) ? 32'h0 : model_load(f3, a);
    e_nwr   = (!e_err && we) ? 1 : 0;
    e_lat   = (!e_err && we && f3 != 3'd2) ? 3 : 2;
    e_waddr = AW'((ad / 4) * 4);
    e_wdata = 32'h0;
    if (e_nwr == 1) begin
      e_wdata = model_store(f3, a, wd);
      model[ad / 4] = e_wdata;
    end

    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (req_ready) bad = 1'b1;
      if (mem_addr[1:0] != 2'b00) bad = 1'b1;
      if (!mem_wr_en && mem_wr_data != 32'h0) bad = 1'b1;
      if (mem_wr_en) begin
        nwr++;
        wa_seen = 32'(mem_addr);
        wd_seen = mem_wr_data;
      end
      if (resp_valid) begin
        lat     = k;
        rd_seen = resp_rdata;
        er_seen = resp_err;
        break;
      end else if (resp_rdata != 32'h0 || resp_err) begin
        bad = 1'b1;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".rdata"}, rd_seen, e_rd);
    check({tag, ".err"}, 32'(er_seen), 32'(e_err));
    check({tag, ".nwr"}, 32'(nwr), 32'(e_nwr));
    if (e_nwr == 1) begin
      check({tag, ".waddr"}, wa_seen, 32'(e_waddr));
      check({tag, ".wdata"}, wd_seen, e_wdata);
    end
    check({tag, ".quiet"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({tag, ".post"},
          {28'h0, req_ready, resp_valid, resp_err, |resp_rdata}, 32'h8);
  endtask

  typedef struct {
    logic          we;
    logic [2:0]    f3;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } req_t;

  logic [2:0] f3_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};

  initial begin
    req_t       hold [6];
    logic [31:0] q_rd [$];
    logic        q_err [$];
    int          accepts, nresp, idx;
    bit          acc_prev, seen;
    logic [31:0] rd_v;
    logic        er_v;

    reset_n    = 1'b0;
    tb_clear   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = 32'h0;
    for (int i = 0; i < NW; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.outs",
          {29'h0, resp_valid, resp_err, mem_wr_en}
          | resp_rdata | mem_wr_data | 32'(mem_addr), 32'h0);
    reset_n  = 1'b1;
    tb_clear = 1'b0;

    do_req(1'b1, 3'd2, 10'h010, 32'h8899aabb, "sw10");
    do_req(1'b0, 3'd2, 10'h010, 32'h0, "lw10");
    do_req(1'b1, 3'd0, 10'h012, 32'hdead0055, "sb12");
    do_req(1'b1, 3'd1, 10'h012, 32'hbeef1234, "sh12");
    do_req(1'b0, 3'd2, 10'h010, 32'h0, "lw10b");
    check("lw10b.literal", model[4], 32'h1234aabb);

    do_req(1'b1, 3'd2, 10'h020, 32'h80ff7f01, "sw20");
    do_req(1'b0, 3'd0, 10'h023, 32'h0, "lb23");
    do_req(1'b0, 3'd4, 10'h023, 32'h0, "lbu23");
    do_req(1'b0, 3'd1, 10'h022, 32'h0, "lh22");
    do_req(1'b0, 3'd5, 10'h020, 32'h0, "lhu20");
    do_req(1'b0, 3'd2, 10'h021, 32'h0, "lw21");
    do_req(1'b1, 3'd1, 10'h023, 32'h1111, "sh23");
    do_req(1'b0, 3'd2, AW'(DEPTH), 32'h0, "lwdepth");
    do_req(1'b0, 3'd2, AW'(DEPTH - 4), 32'h0, "lwlast");
    do_req(1'b1, 3'd4, 10'h030, 32'h5, "sbu_illegal");
    do_req(1'b0, 3'd3, 10'h030, 32'h0, "ld_illegal");

    // Reset while the sub-word store is in its write cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 10'h012;
    req_wdata  = 32'h77;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstrmw.seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstrmw.outs",
          {29'h0, resp_valid, resp_err, mem_wr_en}
          | resp_rdata | mem_wr_data | 32'(mem_addr), 32'h0);
    check("rstrmw.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstrmw.ready2", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'd2, 10'h010, 32'h0, "rstrmw.lw");

    // Continuously held request stream, alternating loads and stores.
    hold[0] = '{1'b0, 3'd2, 10'h040, 32'h0};
    hold[1] = '{1'b1, 3'd2, 10'h040, 32'hcafef00d};
    hold[2] = '{1'b0, 3'd2, 10'h040, 32'h0};
    hold[3] = '{1'b1, 3'd2, 10'h044, 32'h01234567};
    hold[4] = '{1'b0, 3'd2, 10'h044, 32'h0};
    hold[5] = '{1'b1, 3'd2, 10'h040, 32'h0badc0de};
    accepts  = 0;
    nresp    = 0;
    idx      = 0;
    acc_prev = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = hold[0].we;
    req_funct3 = hold[0].f3;
    req_addr   = hold[0].a;
    req_wdata  = hold[0].d;
    for (int cyc = 0; cyc < 60 && nresp < 6; cyc++) begin
      if (resp_valid) begin
        if (q_rd.size() > 0) begin
          rd_v = q_rd.pop_front();
          er_v = q_err.pop_front();
        end else begin
          rd_v = 32'hxxxxxxxx;
          er_v = 1'bx;
        end
        check($sformatf("hold.rdata%0d", nresp), resp_rdata, rd_v);
        check($sformatf("hold.err%0d", nresp), 32'(resp_err), 32'(er_v));
        nresp++;
      end
      if (acc_prev) begin
        idx++;
        if (idx < 6) begin
          req_we     = hold[idx].we;
          req_funct3 = hold[idx].f3;
          req_addr   = hold[idx].a;
          req_wdata  = hold[idx].d;
        end else begin
          req_valid = 1'b0;
        end
      end
      acc_prev = req_valid && req_ready;
      if (acc_prev) begin
        accepts++;
        q_err.push_back(model_err(req_we, req_funct3, req_addr));
        if (req_we) begin
          q_rd.push_back(32'h0);
          model[int'(req_addr) / 4] =
            model_store(req_funct3, req_addr, req_wdata);
        end else begin
          q_rd.push_back(model_load(req_funct3, req_addr));
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hold.accepts", 32'(accepts), 32'd6);
    check("hold.resps", 32'(nresp), 32'd6);
    do_req(1'b0, 3'd2, 10'h040, 32'h0, "hold.lw40");
    do_req(1'b0, 3'd2, 10'h044, 32'h0, "hold.lw44");

    // Random mix, including illegal funct3 and out-of-range addresses.
    for (int n = 0; n < 40; n++) begin
      logic          r_we;
      logic [2:0]    r_f3;
      logic [AW-1:0] r_a;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = f3_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0)
        r_a = AW'($urandom_range(0, DEPTH + 15));
      else
        r_a = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_req(r_we, r_f3, r_a, $urandom, $sformatf("rnd%0d", n));
    end
    for (int w = 0; w < 16; w++)
      do_req(1'b0, 3'd2, AW'(w * 4), 32'h0, $sformatf("final%0d", w));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting between the MEM stage of the 5-stage pipeline and the word-wide data memory. It accepts one RISC-V load or store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and turns it into word-aligned memory accesses. Sub-word stores become a read-modify-write, because the memory only writes full 32-bit words. Load data returns lane-shifted and sign- or zero-extended, and misaligned or out-of-range accesses are reported as errors without touching memory.

## Interface
- DMEM_ADDR_WIDTH, `DMEM_ADDR_WIDTH, byte-address width of memory and request address
- DMEM_DEPTH, `DMEM_DEPTH, memory size in bytes, multiple of 4
- REG_WIDTH, `REG_WIDTH, data width; fixed at 32 for lane logic
- clk  input  1  clock; all state on posedge
- reset_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  DMEM_ADDR_WIDTH  byte address
- req_wdata  input  REG_WIDTH  store data; low byte/halfword used for SB/SH
- resp_valid  output  1  one-cycle pulse, request completed
- resp_rdata  output  REG_WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  valid with resp_valid; misaligned, out-of-range or illegal funct3
- mem_wr_en  output  1  memory write enable
- mem_addr  output  DMEM_ADDR_WIDTH  word-aligned address, low 2 bits always 0
- mem_wr_data  output  REG_WIDTH  full-word write data, little-endian
- mem_rd_data  input  REG_WIDTH  word read from mem_addr; valid at the posedge ending a cycle with mem_wr_en=0

## Operation
- Request registers (we, funct3, addr, wdata) are captured at the posedge where req_valid && req_ready.
- Offset is addr[1:0], and the word address is {addr[DMEM_ADDR_WIDTH-1:2], 2'b00}.
- The error check runs at capture:
  - H/HU with addr[0]=1 is an error.
  - W with addr[1:0]≠0 is an error.
  - Word address > DMEM_DEPTH-4 is an error.
  - funct3 outside the legal set (stores: only 000/001/010) is an error.
- States and transitions:
  - IDLE: req_ready=1. On accept, go to ERR if error, else RD for loads, WR for SW, RMW_RD for SB/SH.
  - RD: mem_addr=word, mem_wr_en=0. Capture mem_rd_data at end of cycle, then go to RESP.
  - RMW_RD: same as RD, capturing the old word. Next state is RMW_WR.
  - RMW_WR: mem_wr_en=1. mem_wr_data is the old word with the addressed byte (SB, lane = offset) or halfword (SH, lanes offset, offset+1) replaced by req_wdata[7:0] or [15:0]. Next state is RESP.
  - WR: mem_wr_en=1, mem_wr_data=req_wdata. Next state is RESP.
  - ERR: no memory access. Next state is RESP with resp_err=1.
  - RESP: resp_valid=1 for one cycle. Next state is IDLE.
- Load extraction uses byte = word >> (8·offset) [7:0] and half = word >> (8·offset) [15:0]:
  - LB sign-extends byte[7]; LBU zero-extends.
  - LH sign-extends half[15]; LHU zero-extends.
  - LW passes the word through.
- In every state other than RD/RMW_RD/RMW_WR/WR, mem_wr_en=0, mem_addr=0, mem_wr_data=0. In RD/RMW_RD, mem_wr_data=0.
- resp_rdata and resp_err are 0 whenever resp_valid=0.
- No response backpressure: the pipeline stalls on req_ready=0.

## Timing
- Reset (asynchronous, any state): state=IDLE and all request/capture registers cleared.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - A reset during RMW_WR aborts the operation. The memory write is either committed whole at the edge or not at all, never partial.
- Accept edge = T0. Latency to resp_valid high:
  - Load: T0+2 (RD, RESP).
  - SW: T0+2 (WR, RESP).
  - SB/SH: T0+3 (RMW_RD, RMW_WR, RESP).
  - Error: T0+2 (ERR, RESP).
- req_ready falls the cycle after accept and returns in the cycle after RESP. Back-to-back throughput is 1 request per 3 cycles (load/SW) or 4 cycles (SB/SH).
- Memory outputs are decoded from the state register only, so they are glitch-free relative to request inputs.
- Requests presented while req_ready=0 are ignored and must be held by the source.

## Test plan
- SW addr 0x10, data 0x8899AABB -> mem_wr_en=1 with mem_addr=0x10 for exactly 1 cycle, resp_valid at T0+2 with resp_rdata=0, resp_err=0; a following LW 0x10 returns 0x8899AABB.
- After that, SB addr 0x12, data 0x55 -> RMW read 0x8899AABB, then write 0x8855AABB at 0x10, resp at T0+3; SH addr 0x12, data 0x1234 then LW 0x10 -> 0x1234AABB.
- With word 0x80FF7F01 at 0x20: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
- Misaligned LW 0x21, misaligned SH 0x23, and LW at DMEM_DEPTH -> resp_err=1, resp_rdata=0, mem_wr_en never asserted, resp at T0+2.
- Assert reset_n low during RMW_WR of an SB -> all outputs zero immediately; after release req_ready=1, and LW shows either the old or the fully merged word.
- Hold req_valid=1 continuously with alternating LW/SW -> exactly one accept per req_ready pulse, no request dropped or duplicated.
